// File: rtl/apb_uart_pkg.sv
// -----------------------------------------------------------------------------
// apb_uart_pkg
// Shared definitions for the UART APB register interface:
//   - register word indices (PADDR[4:2]) for the five mapped registers
//   - CTRL bit positions and STATUS bit layout
//   - APB slave phase enumeration used by the transfer FSM
// No ports (package).
// -----------------------------------------------------------------------------
package apb_uart_pkg;

  // Register word indices, i.e. byte offset >> 2.
  localparam logic [2:0] REG_TX_DATA  = 3'd0;  // 0x00 WO
  localparam logic [2:0] REG_RX_DATA  = 3'd1;  // 0x04 RO
  localparam logic [2:0] REG_CTRL     = 3'd2;  // 0x08 RW
  localparam logic [2:0] REG_BAUD_DIV = 3'd3;  // 0x0C RW
  localparam logic [2:0] REG_STATUS   = 3'd4;  // 0x10 RO + W1C

  // CTRL register bit positions.
  localparam int CTRL_WIDTH      = 5;
  localparam int CTRL_TX_EN      = 0;
  localparam int CTRL_RX_EN      = 1;
  localparam int CTRL_PARITY_EN  = 2;
  localparam int CTRL_PARITY_ODD = 3;
  localparam int CTRL_STOP2      = 4;

  // STATUS bit that is write-one-to-clear.
  localparam int STATUS_OVERRUN_BIT = 4;

  // STATUS[4:0], MSB first.
  typedef struct packed {
    logic rx_overrun;
    logic rx_empty;
    logic rx_full;
    logic tx_empty;
    logic tx_full;
  } status_t;

  // Phase of the APB transfer seen in the current cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    WAIT   = 2'd2,
    ACCESS = 2'd3
  } apb_state_e;

endpackage : apb_uart_pkg

// File: rtl/apb_uart_fifo.sv
// -----------------------------------------------------------------------------
// apb_uart_fifo
// Synchronous FIFO with a first-word-fall-through head output.
// Pointers carry one extra wrap bit: empty when pointers are equal, full when
// only the wrap bits differ. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; a pop from an empty FIFO is ignored.
//
// Ports:
//   clk_i    in   1      clock
//   rst_i    in   1      synchronous active-high reset (flushes the FIFO)
//   push_i   in   1      write data_i at the tail
//   data_i   in   WIDTH  data to push
//   pop_i    in   1      drop the head entry
//   head_o   out  WIDTH  current head entry, 0 while empty
//   full_o   out  1      DEPTH entries stored
//   empty_o  out  1      no entries stored
// -----------------------------------------------------------------------------
module apb_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // When full, the slot being written is the head being popped this cycle,
  // so push-with-pop on a full FIFO is safe.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity and
  // the head is masked to 0 while empty, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule : apb_uart_fifo

// File: rtl/apb_uart_regif.sv
// -----------------------------------------------------------------------------
// apb_uart_regif
// APB slave register interface for the UART. Decodes APB transfers into the
// CTRL and BAUD_DIV configuration registers, TX FIFO pushes, RX FIFO pops and
// the STATUS register (rx_overrun is sticky, write-one-to-clear).
//
// Build option:
//   APB_UART_WAIT_STATE_EN  defined: every transfer gets one wait state
//                           (PREADY low in the first enable cycle).
//                           undefined: zero-wait transfers.
//
// Ports:
//   PCLK        in   1             clock
//   PRESET      in   1             synchronous active-high reset
//   PADDR       in   ADDR_WIDTH    byte address, PADDR[4:2] selects register
//   PSEL        in   1             slave select
//   PENABLE     in   1             access phase
//   PWRITE      in   1             1 = write, 0 = read
//   PWDATA      in   DATA_WIDTH    write data
//   PSTRB       in   DATA_WIDTH/8  write byte strobes
//   PRDATA      out  DATA_WIDTH    read data (0 outside a completing read)
//   PREADY      out  1             transfer completes this cycle
//   PSLVERR     out  1             transfer error, valid with PREADY
//   tx_data_o   out  8             TX FIFO head to the serializer
//   tx_valid_o  out  1             TX FIFO not empty
//   tx_ready_i  in   1             serializer takes the head this cycle
//   rx_data_i   in   8             byte from the deserializer
//   rx_valid_i  in   1             push strobe for rx_data_i
//   ctrl_o      out  5             CTRL register
//   baud_div_o  out  16            BAUD_DIV register
// -----------------------------------------------------------------------------
module apb_uart_regif
  import apb_uart_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BAUD_RST   = 16'd27
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_valid_i,
  output logic [4:0]              ctrl_o,
  output logic [15:0]             baud_div_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

`ifdef APB_UART_WAIT_STATE_EN
  localparam apb_state_e FIRST_ENABLE = WAIT;
`else
  localparam apb_state_e FIRST_ENABLE = ACCESS;
`endif

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  apb_state_e            state_q, state_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [15:0]           baud_q, baud_d;
  logic                  overrun_q, overrun_d;

  logic                  tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]            tx_head;
  logic                  rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]            rx_head;

  logic [2:0]            reg_idx;
  logic                  upper_zero;
  logic                  in_access;
  logic                  dec_err;
  logic [DATA_WIDTH-1:0] dec_rdata;
  logic                  done_ok;
  status_t               status;

  logic                  wr_ctrl, wr_baud, clr_overrun, set_overrun;
  logic                  unused_bits;

  // ---------------------------------------------------------------------------
  // Transfer FSM. state_q is the phase of the previous cycle; state_d is the
  // phase of the current cycle, so PREADY can rise in the first enable cycle
  // without waiting for a register to catch up.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that leaves a
  // variable unassigned would infer a latch.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) state_d = SETUP;
      end
      SETUP: begin
        if (PSEL) state_d = PENABLE ? FIRST_ENABLE : SETUP;
      end
      WAIT: begin
        if (PSEL) state_d = PENABLE ? ACCESS : SETUP;
      end
      ACCESS: begin
        if (PSEL && !PENABLE) state_d = SETUP;
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle is never a completion cycle.
    if (PRESET) state_d = IDLE;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Reaching ACCESS implies PSEL & PENABLE, and ACCESS always completes.
  assign in_access = (state_d == ACCESS);

  // ---------------------------------------------------------------------------
  // Address decode and read mux
  // ---------------------------------------------------------------------------
  assign reg_idx    = PADDR[4:2];
  assign upper_zero = (PADDR[ADDR_WIDTH-1:5] == '0);

  assign status = '{
    rx_overrun: overrun_q,
    rx_empty:   rx_empty,
    rx_full:    rx_full,
    tx_empty:   tx_empty,
    tx_full:    tx_full
  };

  always_comb begin
    dec_err   = 1'b0;
    dec_rdata = '0;
    if (!upper_zero) begin
      dec_err = 1'b1;
    end else begin
      unique case (reg_idx)
        REG_TX_DATA: begin
          // Full is judged before any same-cycle serializer pop.
          if (!PWRITE || (PSTRB[0] && tx_full)) dec_err = 1'b1;
        end
        REG_RX_DATA: begin
          if (PWRITE || rx_empty) dec_err   = 1'b1;
          else                    dec_rdata = DATA_WIDTH'(rx_head);
        end
        REG_CTRL:     dec_rdata = DATA_WIDTH'(ctrl_q);
        REG_BAUD_DIV: dec_rdata = DATA_WIDTH'(baud_q);
        REG_STATUS:   dec_rdata = DATA_WIDTH'(status);
        default:      dec_err   = 1'b1;
      endcase
    end
  end

  assign PREADY  = in_access;
  assign PSLVERR = in_access && dec_err;
  assign PRDATA  = (in_access && !PWRITE) ? dec_rdata : '0;
  assign done_ok = in_access && !dec_err;

  // ---------------------------------------------------------------------------
  // Side-effect strobes (completion cycle, error-free transfers only)
  // ---------------------------------------------------------------------------
  assign tx_push     = done_ok &&  PWRITE && (reg_idx == REG_TX_DATA) && PSTRB[0];
  assign rx_pop      = done_ok && !PWRITE && (reg_idx == REG_RX_DATA);
  assign wr_ctrl     = done_ok &&  PWRITE && (reg_idx == REG_CTRL);
  assign wr_baud     = done_ok &&  PWRITE && (reg_idx == REG_BAUD_DIV);
  assign clr_overrun = done_ok &&  PWRITE && (reg_idx == REG_STATUS) &&
                       PWDATA[STATUS_OVERRUN_BIT];

  assign tx_pop      = tx_valid_o && tx_ready_i;

  // A byte arriving on a full RX FIFO is kept only if the bus pops it to make
  // room in the same cycle; otherwise it is dropped and flagged.
  assign rx_push     = rx_valid_i && (!rx_full || rx_pop);
  assign set_overrun = rx_valid_i &&   rx_full && !rx_pop;

  // ---------------------------------------------------------------------------
  // Configuration and status registers
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d    = ctrl_q;
    baud_d    = baud_q;
    overrun_d = overrun_q;
    if (wr_ctrl && PSTRB[0]) ctrl_d = PWDATA[CTRL_WIDTH-1:0];
    if (wr_baud) begin
      if (PSTRB[0]) baud_d[7:0]  = PWDATA[7:0];
      if (PSTRB[1]) baud_d[15:8] = PWDATA[15:8];
    end
    // A new overrun in the clearing cycle wins so the event is not lost.
    if (clr_overrun) overrun_d = 1'b0;
    if (set_overrun) overrun_d = 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_q    <= '0;
      baud_q    <= BAUD_RST;
      overrun_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      baud_q    <= baud_d;
      overrun_q <= overrun_d;
    end
  end

  assign ctrl_o     = ctrl_q;
  assign baud_div_o = baud_q;

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  apb_uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .push_i  (tx_push),
    .data_i  (PWDATA[7:0]),
    .pop_i   (tx_pop),
    .head_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  apb_uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .push_i  (rx_push),
    .data_i  (rx_data_i),
    .pop_i   (rx_pop),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign tx_data_o  = tx_head;
  assign tx_valid_o = !tx_empty;

  // Byte-offset bits, upper data lanes and their strobes carry no state.
  assign unused_bits = ^{PADDR[1:0], PWDATA[DATA_WIDTH-1:16], PSTRB[STRB_WIDTH-1:2]};

endmodule : apb_uart_regif

// File: tb/tb_apb_uart_regif.sv
// -----------------------------------------------------------------------------
// tb_apb_uart_regif
// Self-checking bench for apb_uart_regif. A queue-based model of the register
// map predicts PRDATA/PSLVERR for each transfer and the TX byte stream.
// Define APB_UART_WAIT_STATE_EN for both bench and RTL to expect the
// one-wait-state timing.
// -----------------------------------------------------------------------------
module tb_apb_uart_regif;

`ifdef APB_UART_WAIT_STATE_EN
  localparam int EXP_ACC = 2;  // enable cycles per transfer
`else
  localparam int EXP_ACC = 1;
`endif
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        PRESET;
  logic [11:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [4:0]  ctrl_o;
  logic [15:0] baud_div_o;

  always #5 clk = ~clk;

  apb_uart_regif dut (
    .PCLK       (clk),
    .PRESET     (PRESET),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .ctrl_o     (ctrl_o),
    .baud_div_o (baud_div_o)
  );

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [4:0]  m_ctrl;
  logic [15:0] m_baud;
  logic        m_ovr;

  function automatic void m_reset();
    tx_q.delete();
    rx_q.delete();
    m_ctrl = 5'd0;
    m_baud = 16'd27;
    m_ovr  = 1'b0;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s    = 32'd0;
    s[4] = m_ovr;
    s[3] = (rx_q.size() == 0);
    s[2] = (rx_q.size() == DEPTH);
    s[1] = (tx_q.size() == 0);
    s[0] = (tx_q.size() == DEPTH);
    return s;
  endfunction

  function automatic void m_rx(input logic [7:0] b);
    if (rx_q.size() == DEPTH) m_ovr = 1'b1;
    else                      rx_q.push_back(b);
  endfunction

  function automatic void m_xfer(input logic wr, input logic [11:0] a,
                                 input logic [31:0] wd, input logic [3:0] s,
                                 output logic [31:0] rd, output logic er);
    int idx;
    idx = int'(a[4:2]);
    rd  = 32'd0;
    er  = 1'b0;
    if (a[11:5] != 7'd0 || idx > 4) begin
      er = 1'b1;
    end else if (idx == 0) begin
      if (!wr) er = 1'b1;
      else if (s[0]) begin
        if (tx_q.size() == DEPTH) er = 1'b1;
        else                      tx_q.push_back(wd[7:0]);
      end
    end else if (idx == 1) begin
      if (wr || rx_q.size() == 0) er = 1'b1;
      else                        rd = {24'd0, rx_q.pop_front()};
    end else if (idx == 2) begin
      if (wr) begin
        if (s[0]) m_ctrl = wd[4:0];
      end else rd = {27'd0, m_ctrl};
    end else if (idx == 3) begin
      if (wr) begin
        if (s[0]) m_baud[7:0]  = wd[7:0];
        if (s[1]) m_baud[15:8] = wd[15:8];
      end else rd = {16'd0, m_baud};
    end else begin
      if (wr) begin
        if (wd[4]) m_ovr = 1'b0;
      end else rd = m_status();
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Checking and bus tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_apb(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic rx_at_done,
                        input logic [7:0] rxb, input string tag);
    logic [31:0] exp_rd, got_rd;
    logic        exp_er, got_er, seen;
    int          n;
    m_xfer(wr, a, wd, s, exp_rd, exp_er);
    if (rx_at_done) m_rx(rxb);
    got_rd = 32'hDEAD_BEEF;
    got_er = 1'bx;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = s;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      n++;
      rx_valid_i = rx_at_done && (n == EXP_ACC);
      rx_data_i  = rxb;
      @(negedge clk);
      if (PREADY) begin
        seen   = 1'b1;
        got_rd = PRDATA;
        got_er = PSLVERR;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; rx_valid_i = 1'b0;
    check({tag, "/ready_cycles"}, n, EXP_ACC);
    check({tag, "/pslverr"}, {31'd0, got_er}, {31'd0, exp_er});
    if (!wr) check({tag, "/prdata"}, got_rd, exp_rd);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    m_rx(b);
    @(posedge clk); #1;
    rx_valid_i = 1'b1; rx_data_i = b;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic drain_tx(input string tag);
    @(posedge clk); #1;
    tx_ready_i = 1'b1;
    while (tx_q.size() > 0) begin
      @(negedge clk);
      check({tag, "/tx_valid"}, {31'd0, tx_valid_o}, 32'd1);
      check({tag, "/tx_data"}, {24'd0, tx_data_o}, {24'd0, tx_q[0]});
      void'(tx_q.pop_front());
    end
    @(negedge clk);
    check({tag, "/tx_valid_end"}, {31'd0, tx_valid_o}, 32'd0);
    @(posedge clk); #1;
    tx_ready_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [11:0] a;
    logic        w;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 PRESET = 1'b0;
    @(negedge clk);
    check("rst/prdata", PRDATA, 32'd0);
    check("rst/pready", {31'd0, PREADY}, 32'd0);
    check("rst/pslverr", {31'd0, PSLVERR}, 32'd0);
    check("rst/tx_valid", {31'd0, tx_valid_o}, 32'd0);
    check("rst/tx_data", {24'd0, tx_data_o}, 32'd0);

    do_apb(0, 12'h00C, 0, 0, 0, 0, "rd_baud_rst");
    do_apb(0, 12'h008, 0, 0, 0, 0, "rd_ctrl_rst");
    do_apb(0, 12'h010, 0, 0, 0, 0, "rd_status_rst");

    do_apb(1, 12'h008, 32'h0000_001F, 4'b0001, 0, 0, "wr_ctrl");
    do_apb(0, 12'h008, 0, 0, 0, 0, "rd_ctrl");
    check("ctrl_o", {27'd0, ctrl_o}, {27'd0, m_ctrl});
    do_apb(1, 12'h00C, 32'hABCD_1234, 4'b0010, 0, 0, "wr_baud_lane1");
    do_apb(0, 12'h00C, 0, 0, 0, 0, "rd_baud");
    check("baud_div_o", {16'd0, baud_div_o}, {16'd0, m_baud});

    for (int i = 0; i < DEPTH + 1; i++)
      do_apb(1, 12'h000, i, 4'b0001, 0, 0, $sformatf("tx_push%0d", i));
    do_apb(1, 12'h000, 32'h55, 4'b0000, 0, 0, "tx_nostrb_full");
    do_apb(0, 12'h010, 0, 0, 0, 0, "status_tx_full");
    drain_tx("drain1");

    for (int i = 0; i < DEPTH + 1; i++) rx_byte(8'hA0 + 8'(i));
    do_apb(0, 12'h010, 0, 0, 0, 0, "status_rx_ovr");
    for (int i = 0; i < DEPTH + 1; i++)
      do_apb(0, 12'h004, 0, 0, 0, 0, $sformatf("rx_pop%0d", i));
    do_apb(1, 12'h010, 32'h10, 4'b1111, 0, 0, "w1c_ovr");
    do_apb(0, 12'h010, 0, 0, 0, 0, "status_cleared");

    do_apb(0, 12'h014, 0, 0, 0, 0, "rd_unmapped");
    do_apb(1, 12'h004, 32'h99, 4'b1111, 0, 0, "wr_rx_data");
    do_apb(0, 12'h000, 0, 0, 0, 0, "rd_tx_data");
    do_apb(1, 12'h208, 32'h3, 4'b1111, 0, 0, "wr_upper_addr");
    do_apb(0, 12'h008, 0, 0, 0, 0, "ctrl_after_errs");
    do_apb(0, 12'h010, 0, 0, 0, 0, "status_after_errs");

    // Full RX FIFO: pop and push in the same cycle, no overrun.
    for (int i = 0; i < DEPTH; i++) rx_byte(8'h30 + 8'(i));
    do_apb(0, 12'h004, 0, 0, 1, 8'hEE, "rx_pop_push_full");
    do_apb(0, 12'h010, 0, 0, 0, 0, "status_no_ovr");

    // PSEL dropped after SETUP: abandoned, no push.
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h000;
    PWDATA = 32'h5A; PSTRB = 4'hF;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b1;
    @(negedge clk);
    check("abort/pready", {31'd0, PREADY}, 32'd0);
    @(posedge clk); #1;
    PENABLE = 1'b0;
    do_apb(0, 12'h010, 0, 0, 0, 0, "status_after_abort");

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        rx_byte(8'($urandom));
      end else begin
        a = {7'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 15) == 0) a[11:5] = 7'($urandom_range(1, 127));
        w = 1'($urandom_range(0, 1));
        do_apb(w, a, $urandom, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 7) == 0), 8'($urandom),
               $sformatf("rnd%0d", i));
      end
    end
    do_apb(0, 12'h010, 0, 0, 0, 0, "status_after_rnd");
    drain_tx("drain2");

    // Reset during the first enable cycle of a TX push.
    do_apb(1, 12'h000, 32'h42, 4'b0001, 0, 0, "pre_reset_push");
    rx_byte(8'h11);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h000;
    PWDATA = 32'h77; PSTRB = 4'b0001;
    @(posedge clk); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge clk); #1;
    PRESET = 1'b0;
    m_reset();
    @(negedge clk);
    check("midrst/pready", {31'd0, PREADY}, 32'd0);
    check("midrst/prdata", PRDATA, 32'd0);
    check("midrst/tx_valid", {31'd0, tx_valid_o}, 32'd0);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    do_apb(0, 12'h010, 0, 0, 0, 0, "status_after_midrst");
    do_apb(0, 12'h00C, 0, 0, 0, 0, "baud_after_midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_apb_uart_regif
